ram4x4_initiator: RTL and testbench

- Host-side initiator for the 4-word x 4-bit register-file RAM.
- Accepts single write, single read, full dump and full clear commands over a valid/ready command channel.
- Drives the RAM's address, data and write-strobe inputs from registers. The integrator ANDs ram_we with clk to form the per-word gated clocks.
- Samples the RAM's combinational mux output and returns read data over a valid/ready response channel.

---
 rtl/ram_init_pkg.sv | 20 ++
 rtl/ram_addr_seq.sv | 42 ++++
 rtl/ram4x4_initiator.sv | 182 ++++++++++++++++++
 tb/tb_ram4x4_initiator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_init_pkg.sv
// Shared encodings and defaults for the 4-word x 4-bit register-file RAM initiator.
package ram_init_pkg;

    localparam int unsigned RAM_DW = 4;
    localparam int unsigned RAM_AW = 2;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        CLR      = 3'd2,
        RD_SETUP = 3'd3,
        RESP     = 3'd4
    } state_e;

endpackage

// File: rtl/ram_addr_seq.sv
// Loadable word pointer shared by DUMP and CLEAR; flags the final word of the array.
module ram_addr_seq #(
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o,
    output logic [AW-1:0] next_o,
    output logic          last_o
);

    // DEPTH-1 is all ones for a power-of-two depth; the pointer simply wraps past it.
    localparam logic [AW-1:0] LAST_PTR = '1;

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign next_o = ptr_d;
    assign last_o = (ptr_q == LAST_PTR);

endmodule

// File: rtl/ram4x4_initiator.sv
// Host-side command/response initiator driving a gated-clock register-file RAM.
module ram4x4_initiator
    import ram_init_pkg::*;
#(
    parameter int unsigned DW = RAM_DW,
    parameter int unsigned AW = RAM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_last,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic          ram_we_q, ram_we_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0] rsp_addr_q, rsp_addr_d;
    logic          rsp_last_q, rsp_last_d;

    logic          seq_load;
    logic [AW-1:0] seq_load_val;
    logic          seq_inc;
    logic [AW-1:0] seq_ptr;
    logic [AW-1:0] seq_next;
    logic          seq_last;

    ram_addr_seq #(.AW(AW)) u_seq (
        .clk        (clk),
        .rst        (rst),
        .load_i     (seq_load),
        .load_val_i (seq_load_val),
        .inc_i      (seq_inc),
        .ptr_o      (seq_ptr),
        .next_o     (seq_next),
        .last_o     (seq_last)
    );

    assign cmd_ready = (state_q == IDLE) && !rst;

    // RAM-side registers are loaded with the values for the state being entered,
    // so ram_we/ram_addr/ram_d are valid for the whole cycle spent in WR/CLR/RD_SETUP.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        ram_addr_d   = ram_addr_q;
        ram_d_d      = ram_d_q;
        ram_we_d     = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_last_d   = rsp_last_q;
        seq_load     = 1'b0;
        seq_load_val = '0;
        seq_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d = cmd_op;
                    case (cmd_op)
                        OP_WRITE: begin
                            state_d    = WR;
                            ram_we_d   = 1'b1;
                            ram_addr_d = cmd_addr;
                            ram_d_d    = cmd_wdata;
                        end
                        OP_READ: begin
                            state_d      = RD_SETUP;
                            seq_load     = 1'b1;
                            seq_load_val = cmd_addr;
                            ram_addr_d   = cmd_addr;
                        end
                        OP_DUMP: begin
                            state_d      = RD_SETUP;
                            seq_load     = 1'b1;
                            seq_load_val = '0;
                            ram_addr_d   = '0;
                        end
                        default: begin
                            state_d      = CLR;
                            seq_load     = 1'b1;
                            seq_load_val = '0;
                            ram_addr_d   = '0;
                            ram_d_d      = '0;
                            ram_we_d     = 1'b1;
                        end
                    endcase
                end
            end

            WR: begin
                state_d = IDLE;
            end

            CLR: begin
                if (seq_last) begin
                    state_d = IDLE;
                end else begin
                    seq_inc    = 1'b1;
                    ram_addr_d = seq_next;
                    ram_we_d   = 1'b1;
                end
            end

            RD_SETUP: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = ram_q;
                rsp_addr_d  = seq_ptr;
                rsp_last_d  = (op_q == OP_READ) || seq_last;
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if ((op_q == OP_READ) || seq_last) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = RD_SETUP;
                        seq_inc    = 1'b1;
                        ram_addr_d = seq_next;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_WRITE;
            ram_addr_q  <= '0;
            ram_d_q     <= '0;
            ram_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ram_addr_q  <= ram_addr_d;
            ram_d_q     <= ram_d_d;
            ram_we_q    <= ram_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_d     = ram_d_q;
    assign ram_we    = ram_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram4x4_initiator.sv
// Directed bench for ram4x4_initiator paired with a 4-word x 4-bit RAM model.
module tb_ram4x4_initiator;
    import ram_init_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_addr;
    logic [3:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [1:0] rsp_addr;
    logic       rsp_last;
    logic [1:0] ram_addr;
    logic [3:0] ram_d;
    logic       ram_we;
    logic [3:0] ram_q;
    logic       busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    ram4x4_initiator #(.DW(4), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_last  (rsp_last),
        .ram_addr  (ram_addr),
        .ram_d     (ram_d),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .busy      (busy)
    );

    // RAM model: words latch on the closing (falling) edge of the clk & ram_we gated clock.
    logic [3:0] mem [4];
    always @(negedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
    end
    assign ram_q = mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0]  stim; // {vld, op, addr, wdata, rdy}
        logic [16:0] exp;  // {cmd_ready, busy, we, ram_addr, ram_d, rsp_valid, rsp_data, rsp_addr, rsp_last}
    } vec_t;

    vec_t tv[$];

    function automatic logic [9:0] S(input logic v, input logic [1:0] op, input logic [1:0] a,
                                     input logic [3:0] d, input logic r);
        return {v, op, a, d, r};
    endfunction

    function automatic logic [16:0] E(input logic cr, input logic bz, input logic we,
                                      input logic [1:0] ra, input logic [3:0] rd, input logic rv,
                                      input logic [3:0] rdat, input logic [1:0] radr, input logic rl);
        return {cr, bz, we, ra, rd, rv, rdat, radr, rl};
    endfunction

    function automatic logic [16:0] obs();
        return {cmd_ready, busy, ram_we, ram_addr, ram_d, rsp_valid, rsp_data, rsp_addr, rsp_last};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller at the falling edge of the first cycle with rsp_valid high.
    task automatic wait_valid(input string name);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s: got no rsp_valid within 8 cycles required rsp_valid=1", name);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] d);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        tick();
    endtask

    task automatic dump_check(input string name, input logic [15:0] exp_words);
        cmd_valid = 1'b1;
        cmd_op    = OP_DUMP;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(name);
            check(name, 32'({rsp_data, rsp_addr, rsp_last}),
                  32'({exp_words[4*k +: 4], 2'(k), (k == 3)}));
            tick();
        end
    endtask

    int unsigned accepts;
    logic [4:0]  rdy_pat;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_WRITE;
        cmd_addr  = 2'd0;
        cmd_wdata = 4'h0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 4'h0;

        tick();
        tick();
        @(negedge clk);
        check("reset_state", 32'(obs()), 32'(E(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0)));
        tick();
        rst = 1'b0;

        // WRITE 2<=A, READ 2, then fill 1..4 and DUMP with rsp_ready held high.
        tv.push_back('{S(1'b1, OP_WRITE, 2'd2, 4'hA, 1'b0), E(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0)});
        tv.push_back('{S(1'b0, OP_WRITE, 2'd0, 4'h0, 1'b0), E(1'b0, 1'b1, 1'b1, 2'd2, 4'hA, 1'b0, 4'h0, 2'd0, 1'b0)});
        tv.push_back('{S(1'b1, OP_READ,  2'd2, 4'h0, 1'b0), E(1'b1, 1'b0, 1'b0, 2'd2, 4'hA, 1'b0, 4'h0, 2'd0, 1'b0)});
        tv.push_back('{S(1'b0, OP_READ,  2'd0, 4'h0, 1'b0), E(1'b0, 1'b1, 1'b0, 2'd2, 4'hA, 1'b0, 4'h0, 2'd0, 1'b0)});
        tv.push_back('{S(1'b0, OP_READ,  2'd0, 4'h0, 1'b0), E(1'b0, 1'b1, 1'b0, 2'd2, 4'hA, 1'b1, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b0, OP_READ,  2'd0, 4'h0, 1'b1), E(1'b0, 1'b1, 1'b0, 2'd2, 4'hA, 1'b1, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b0, OP_READ,  2'd0, 4'h0, 1'b0), E(1'b1, 1'b0, 1'b0, 2'd2, 4'hA, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b1, OP_WRITE, 2'd0, 4'h1, 1'b0), E(1'b1, 1'b0, 1'b0, 2'd2, 4'hA, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b0, OP_WRITE, 2'd0, 4'h0, 1'b0), E(1'b0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b1, OP_WRITE, 2'd1, 4'h2, 1'b0), E(1'b1, 1'b0, 1'b0, 2'd0, 4'h1, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b0, OP_WRITE, 2'd0, 4'h0, 1'b0), E(1'b0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b1, OP_WRITE, 2'd2, 4'h3, 1'b0), E(1'b1, 1'b0, 1'b0, 2'd1, 4'h2, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b0, OP_WRITE, 2'd0, 4'h0, 1'b0), E(1'b0, 1'b1, 1'b1, 2'd2, 4'h3, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b1, OP_WRITE, 2'd3, 4'h4, 1'b0), E(1'b1, 1'b0, 1'b0, 2'd2, 4'h3, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b0, OP_WRITE, 2'd0, 4'h0, 1'b0), E(1'b0, 1'b1, 1'b1, 2'd3, 4'h4, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b1, OP_DUMP,  2'd2, 4'h0, 1'b1), E(1'b1, 1'b0, 1'b0, 2'd3, 4'h4, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b0, OP_DUMP,  2'd0, 4'h0, 1'b1), E(1'b0, 1'b1, 1'b0, 2'd0, 4'h4, 1'b0, 4'hA, 2'd2, 1'b1)});
        tv.push_back('{S(1'b0, OP_DUMP,  2'd0, 4'h0, 1'b1), E(1'b0, 1'b1, 1'b0, 2'd0, 4'h4, 1'b1, 4'h1, 2'd0, 1'b0)});
        tv.push_back('{S(1'b0, OP_DUMP,  2'd0, 4'h0, 1'b1), E(1'b0, 1'b1, 1'b0, 2'd1, 4'h4, 1'b0, 4'h1, 2'd0, 1'b0)});
        tv.push_back('{S(1'b0, OP_DUMP,  2'd0, 4'h0, 1'b1), E(1'b0, 1'b1, 1'b0, 2'd1, 4'h4, 1'b1, 4'h2, 2'd1, 1'b0)});
        tv.push_back('{S(1'b0, OP_DUMP,  2'd0, 4'h0, 1'b1), E(1'b0, 1'b1, 1'b0, 2'd2, 4'h4, 1'b0, 4'h2, 2'd1, 1'b0)});
        tv.push_back('{S(1'b0, OP_DUMP,  2'd0, 4'h0, 1'b1), E(1'b0, 1'b1, 1'b0, 2'd2, 4'h4, 1'b1, 4'h3, 2'd2, 1'b0)});
        tv.push_back('{S(1'b0, OP_DUMP,  2'd0, 4'h0, 1'b1), E(1'b0, 1'b1, 1'b0, 2'd3, 4'h4, 1'b0, 4'h3, 2'd2, 1'b0)});
        tv.push_back('{S(1'b0, OP_DUMP,  2'd0, 4'h0, 1'b1), E(1'b0, 1'b1, 1'b0, 2'd3, 4'h4, 1'b1, 4'h4, 2'd3, 1'b1)});
        tv.push_back('{S(1'b0, OP_DUMP,  2'd0, 4'h0, 1'b0), E(1'b1, 1'b0, 1'b0, 2'd3, 4'h4, 1'b0, 4'h4, 2'd3, 1'b1)});

        foreach (tv[i]) begin
            {cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready} = tv[i].stim;
            @(negedge clk);
            check($sformatf("vec[%0d]", i), 32'(obs()), 32'(tv[i].exp));
            tick();
        end

        // DUMP with the second response stalled; a WRITE offered meanwhile must be ignored.
        cmd_valid = 1'b1;
        cmd_op    = OP_DUMP;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_valid("stall_rsp0");
        check("stall_rsp0", 32'({rsp_data, rsp_addr, rsp_last}), 32'({4'h1, 2'd0, 1'b0}));
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = 2'd0;
        cmd_wdata = 4'hF;
        wait_valid("stall_rsp1");
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_hold[%0d]", k),
                  32'({rsp_valid, rsp_data, rsp_addr, rsp_last, cmd_ready, ram_we, ram_addr}),
                  32'({1'b1, 4'h2, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1}));
            tick();
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        wait_valid("stall_rsp2");
        check("stall_rsp2", 32'({rsp_data, rsp_addr, rsp_last}), 32'({4'h3, 2'd2, 1'b0}));
        tick();
        wait_valid("stall_rsp3");
        check("stall_rsp3", 32'({rsp_data, rsp_addr, rsp_last}), 32'({4'h4, 2'd3, 1'b1}));
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("stall_no_write", 32'({busy, mem[0]}), 32'({1'b0, 4'h1}));
        tick();

        // CLEAR over 0xF: four back-to-back strobes at 0..3 with zero data.
        for (int a = 0; a < 4; a++) do_write(2'(a), 4'hF);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("clr_cycle[%0d]", k), 32'({ram_we, ram_addr, ram_d, busy}),
                  32'({1'b1, 2'(k), 4'h0, 1'b1}));
            tick();
        end
        @(negedge clk);
        check("clr_done", 32'({ram_we, busy, cmd_ready}), 32'({1'b0, 1'b0, 1'b1}));
        tick();
        dump_check("clr_dump", 16'h0000);

        // Reset taken at the edge ending the first clear cycle: only word 0 is cleared.
        for (int a = 0; a < 4; a++) do_write(2'(a), 4'hF);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        tick();
        cmd_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("rst_clr_first", 32'({ram_we, ram_addr, cmd_ready}), 32'({1'b1, 2'd0, 1'b0}));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_after", 32'({ram_we, busy, rsp_valid, cmd_ready, ram_addr}),
              32'({1'b0, 1'b0, 1'b0, 1'b1, 2'd0}));
        tick();
        @(negedge clk);
        check("rst_quiet", 32'({ram_we, busy}), 32'({1'b0, 1'b0}));
        check("rst_mem", 32'({mem[3], mem[2], mem[1], mem[0]}), 32'(16'hFFF0));
        tick();

        // cmd_valid held high across a READ: next accept only after the handshake.
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        cmd_addr  = 2'd1;
        rsp_ready = 1'b0;
        accepts   = 0;
        rdy_pat   = 5'b10001;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) rsp_ready = 1'b1;
            @(negedge clk);
            check($sformatf("hold_ready[%0d]", c), 32'(cmd_ready), 32'(rdy_pat[c]));
            if (cmd_valid && cmd_ready) accepts++;
            if (c == 2) check("hold_rsp", 32'({rsp_valid, rsp_data, rsp_addr, rsp_last}),
                              32'({1'b1, 4'hF, 2'd1, 1'b1}));
            tick();
        end
        check("hold_accepts", 32'(accepts), 32'(2));
        cmd_valid = 1'b0;
        wait_valid("hold_rsp2");
        check("hold_rsp2", 32'({rsp_data, rsp_addr, rsp_last}), 32'({4'hF, 2'd1, 1'b1}));
        tick();
        @(negedge clk);
        check("final_idle", 32'({busy, rsp_valid, cmd_ready}), 32'({1'b0, 1'b0, 1'b1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
